// File: rtl/simmem_pkg.sv
// rtl/simmem_pkg.sv - shared sizing constants and types for the simulated memory controller
package simmem_pkg;

    localparam int WriteRespBankTotalCapacity = 8;
    localparam int WriteRespWidth             = 6;

    typedef logic [$clog2(WriteRespBankTotalCapacity)-1:0] write_resp_slot_t;

endpackage

// File: rtl/simmem_rr_picker.sv
// rtl/simmem_rr_picker.sv - combinational round-robin grant over a candidate vector
module simmem_rr_picker
    import simmem_pkg::*;
#(
    parameter int NumSlots = WriteRespBankTotalCapacity
) (
    input  logic [NumSlots-1:0]         cand_i,
    input  logic [$clog2(NumSlots)-1:0] ptr_i,
    output logic [NumSlots-1:0]         grant_o,
    output logic                        valid_o
);

    localparam int IdxW = $clog2(NumSlots);

    logic [IdxW-1:0] idx;

    // Scan starts at the pointer and wraps, so the first hit is the fair winner.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < NumSlots; i++) begin
            idx = IdxW'((32'(ptr_i) + i) % NumSlots);
            if (!valid_o && cand_i[idx]) begin
                grant_o[idx] = 1'b1;
                valid_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/simmem_resp_releaser.sv
// rtl/simmem_resp_releaser.sv - holds write responses per slot and releases expired ones downstream
module simmem_resp_releaser
    import simmem_pkg::*;
#(
    parameter int NumSlots  = WriteRespBankTotalCapacity,
    parameter int RespWidth = WriteRespWidth
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        wr_valid_i,
    input  logic [$clog2(NumSlots)-1:0] wr_slot_i,
    input  logic [RespWidth-1:0]        wr_data_i,
    output logic [NumSlots-1:0]         free_slots_o,
    input  logic [NumSlots-1:0]         release_en_i,
    output logic [NumSlots-1:0]         address_released_onehot_o,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [RespWidth-1:0]        out_data_o
);

    localparam int IdxW = $clog2(NumSlots);

    logic [NumSlots-1:0]  occupied_q, occupied_d;
    logic [NumSlots-1:0]  in_flight_q, in_flight_d;
    logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
    logic                 out_valid_q, out_valid_d;
    logic [RespWidth-1:0] out_data_q;
    logic [RespWidth-1:0] payload_q [NumSlots];

    logic [NumSlots-1:0]  cand, grant, released, wr_onehot;
    logic                 grant_valid, handshake, load, wr_accept;
    logic [RespWidth-1:0] winner_data;
    logic [IdxW-1:0]      winner_idx;

    assign handshake = out_valid_q & out_ready_i;
    assign released  = handshake ? in_flight_q : '0;
    // The slot already sitting in the output register must not be picked again.
    assign cand      = release_en_i & occupied_q & ~in_flight_q;
    assign load      = (!out_valid_q || out_ready_i) && grant_valid;
    assign wr_accept = wr_valid_i && !occupied_q[wr_slot_i];
    assign wr_onehot = NumSlots'(1) << wr_slot_i;

    simmem_rr_picker #(
        .NumSlots (NumSlots)
    ) u_picker (
        .cand_i  (cand),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .valid_o (grant_valid)
    );

    always_comb begin
        winner_data = '0;
        winner_idx  = '0;
        for (int unsigned i = 0; i < NumSlots; i++) begin
            if (grant[i]) begin
                winner_data = payload_q[i];
                winner_idx  = IdxW'(i);
            end
        end
    end

    always_comb begin
        occupied_d  = (occupied_q & ~released) | (wr_accept ? wr_onehot : '0);
        out_valid_d = load | (out_valid_q & ~out_ready_i);
        in_flight_d = in_flight_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            in_flight_d = grant;
            rr_ptr_d    = IdxW'((32'(winner_idx) + 32'd1) % NumSlots);
        end else if (handshake) begin
            in_flight_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occupied_q  <= '0;
            in_flight_q <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < NumSlots; i++) begin
                payload_q[i] <= '0;
            end
        end else begin
            occupied_q  <= occupied_d;
            in_flight_q <= in_flight_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            if (load) begin
                out_data_q <= winner_data;
            end
            if (wr_accept) begin
                payload_q[wr_slot_i] <= wr_data_i;
            end
        end
    end

    // Overwriting a live response would corrupt it; the write is dropped and reported.
    always @(posedge clk_i) begin
        if (rst_ni && wr_valid_i) begin
            assert (!occupied_q[wr_slot_i])
                else $warning("write to occupied slot %0d ignored", wr_slot_i);
        end
    end

    assign free_slots_o              = ~occupied_q;
    assign address_released_onehot_o = released;
    assign out_valid_o               = out_valid_q;
    assign out_data_o                = out_data_q;

endmodule
